mpu_sample_scheduler: RTL and testbench

Sequencer that owns the MPU6050 I2C transaction engine and turns it into a periodic sensor sampler. After reset it waits a power-up delay and wakes the device by writing PWR_MGMT_1. It then reads the six accelerometer bytes (0x3B..0x40) on every sample tick, retrying NACKed transfers. It assembles them into three signed 16-bit words for downstream consumers (pet activity/step logic). It sits between the I2C byte engine and the application logic and is the only issuer of commands to that engine.

---
 rtl/mpu_sample_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_mpu_sample_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_sample_scheduler.sv
// Purpose : periodic MPU6050 accelerometer sampler driving a single-command I2C byte engine.
// Latency : tick -> first cmd_valid 2 cycles; last rsp_valid -> sample_valid 2 cycles.
// Backpr. : cmd_* held stable until cmd_ready; ticks arriving mid-read are dropped and counted.
//
// Optional build macro: MPU_GYRO_EN adds gyro_x/y/z and extends each sample with regs 0x43..0x48.
//
// Ports:
//   clk, rst_n (sync, active-low), enable (tick timer run), clr_err (leave ERROR, re-init)
//   cmd_valid/cmd_ready/cmd_rw/cmd_dev/cmd_reg/cmd_wdata : command channel to the byte engine
//   rsp_valid/rsp_nack/rsp_data                          : transaction completion from the engine
//   accel_x/y/z (+gyro_x/y/z), sample_valid              : last complete sample, update strobe
//   init_done, error, overrun_cnt                        : status
module mpu_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned PWRUP_DLY  = 10000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [6:0]  DEV_ADDR   = 7'h68
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clr_err,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic [6:0]  cmd_dev,
  output logic [7:0]  cmd_reg,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  input  logic [7:0]  rsp_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
`ifdef MPU_GYRO_EN
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
`endif
  output logic        sample_valid,
  output logic        init_done,
  output logic        error,
  output logic [7:0]  overrun_cnt
);

`ifdef MPU_GYRO_EN
  localparam int NBYTES = 12;
`else
  localparam int NBYTES = 6;
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  localparam int PWR_W = (PWRUP_DLY > 1) ? $clog2(PWRUP_DLY) : 1;
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_DLY - 1);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_CMD,
    S_INIT_RSP,
    S_IDLE,
    S_RD_CMD,
    S_RD_RSP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] tick_cnt;
  logic [PWR_W-1:0] pwr_cnt;
  logic [RTY_W-1:0] retry_cnt;
  logic [3:0]       idx;
  logic [7:0]       stage [NBYTES];
  logic             timer_run;
  logic             tick;

  // Byte index -> register address. With gyro enabled the temperature
  // registers 0x41/0x42 are skipped, so idx 6 maps to 0x43.
  function automatic logic [7:0] rd_reg(input logic [3:0] i);
`ifdef MPU_GYRO_EN
    rd_reg = (i < 4'd6) ? (8'h3B + {4'h0, i}) : (8'h3D + {4'h0, i});
`else
    rd_reg = 8'h3B + {4'h0, i};
`endif
  endfunction

  // Timer only runs once the device is awake and not in error; because it is
  // frozen in ERROR a tick can never coincide with an accepted clr_err.
  assign timer_run = enable && ((state == S_IDLE) || (state == S_RD_CMD) ||
                                (state == S_RD_RSP) || (state == S_DONE));
  assign tick      = timer_run && (tick_cnt == DIV_LAST);

  assign cmd_dev   = DEV_ADDR;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_PWRUP;
      tick_cnt     <= '0;
      pwr_cnt      <= '0;
      retry_cnt    <= '0;
      idx          <= '0;
      cmd_valid    <= 1'b0;
      cmd_rw       <= 1'b0;
      cmd_reg      <= 8'h00;
      cmd_wdata    <= 8'h00;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
`ifdef MPU_GYRO_EN
      gyro_x       <= '0;
      gyro_y       <= '0;
      gyro_z       <= '0;
`endif
      sample_valid <= 1'b0;
      init_done    <= 1'b0;
      error        <= 1'b0;
      overrun_cnt  <= '0;
      for (int i = 0; i < NBYTES; i++) stage[i] <= 8'h00;
    end else begin
      sample_valid <= 1'b0;

      if (!timer_run)  tick_cnt <= '0;
      else if (tick)   tick_cnt <= '0;
      else             tick_cnt <= tick_cnt + 1'b1;

      // Only IDLE can start a read; any other tick is lost.
      if (tick && (state != S_IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;

      case (state)
        S_PWRUP: begin
          if (pwr_cnt == PWR_LAST) begin
            pwr_cnt <= '0;
            state   <= S_INIT_CMD;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end

        S_INIT_CMD: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_rw    <= 1'b0;
            cmd_reg   <= 8'h6B;      // PWR_MGMT_1: clear SLEEP
            cmd_wdata <= 8'h00;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_INIT_RSP;
          end
        end

        S_INIT_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              init_done <= 1'b1;
              retry_cnt <= '0;
              state     <= S_IDLE;
            end else if (retry_cnt < RTY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_INIT_CMD;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end

        S_IDLE: begin
          if (tick) begin
            idx   <= '0;
            state <= S_RD_CMD;
          end
        end

        S_RD_CMD: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_rw    <= 1'b1;
            cmd_reg   <= rd_reg(idx);
            cmd_wdata <= 8'h00;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_RD_RSP;
          end
        end

        S_RD_RSP: begin
          if (rsp_valid) begin
            if (!rsp_nack) begin
              for (int i = 0; i < NBYTES; i++)
                if (idx == 4'(i)) stage[i] <= rsp_data;
              retry_cnt <= '0;
              if (idx == LAST_IDX) begin
                state <= S_DONE;
              end else begin
                idx   <= idx + 4'd1;
                state <= S_RD_CMD;
              end
            end else if (retry_cnt < RTY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_RD_CMD;
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
        end

        S_DONE: begin
          // Published words change only here, so aborted reads never leak out.
          accel_x      <= {stage[0], stage[1]};
          accel_y      <= {stage[2], stage[3]};
          accel_z      <= {stage[4], stage[5]};
`ifdef MPU_GYRO_EN
          gyro_x       <= {stage[6],  stage[7]};
          gyro_y       <= {stage[8],  stage[9]};
          gyro_z       <= {stage[10], stage[11]};
`endif
          sample_valid <= 1'b1;
          idx          <= '0;
          state        <= S_IDLE;
        end

        S_ERROR: begin
          error     <= 1'b1;
          cmd_valid <= 1'b0;
          if (clr_err) begin
            error     <= 1'b0;
            init_done <= 1'b0;
            pwr_cnt   <= '0;
            retry_cnt <= '0;
            idx       <= '0;
            for (int i = 0; i < NBYTES; i++) stage[i] <= 8'h00;
            state     <= S_PWRUP;
          end
        end

        default: state <= S_PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_sample_scheduler.sv
module tb_mpu_sample_scheduler;

  logic        clk;
  logic        rst_n, enable, clr_err;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg, cmd_wdata;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, error;
  logic [7:0]  overrun_cnt;

  mpu_sample_scheduler #(
    .SAMPLE_DIV(50), .PWRUP_DLY(8), .MAX_RETRY(3), .DEV_ADDR(7'h68)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .error(error),
    .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_samples = 0;
  int n_acks = 0;
  int last_rsp_cyc = 0;
  int ready_lat = 3;
  int rsp_lat = 3;
  bit cmd_chk = 1'b1;
  bit ov_phase = 1'b0;
  int ov_last = 0;

  logic [23:0] exp_cmd_q [$];   // {dev, rw, reg, wdata}
  logic [47:0] exp_smp_q [$];   // {x, y, z}
  logic [7:0]  data_tbl [256];
  int          nack_left [256];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #3;
  endtask

  task automatic push_rd(input logic [7:0] r);
    exp_cmd_q.push_back({7'h68, 1'b1, r, 8'h00});
  endtask

  task automatic log_cmd(input logic [23:0] c);
    if (cmd_chk) begin
      if (exp_cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected actual=0x%0h required=none", c);
      end else begin
        chk("cmd", {24'h0, c}, {24'h0, exp_cmd_q.pop_front()});
      end
    end
  endtask

  task automatic wait_samples(input int target, input int bound, input string nm);
    int n;
    n = 0;
    while (n_samples < target && n < bound) begin
      step;
      n++;
    end
    chk(nm, n_samples >= target, 1);
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Engine model: ready after 3 valid cycles, response rsp_lat cycles after handshake.
  initial begin : engine
    int st, cnt, ri;
    logic [23:0] cur;
    logic [7:0] reg_a;
    logic [7:0] rec [6];
    st = 0; cnt = 0; cur = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        st = 0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
      end else begin
        case (st)
          0: if (cmd_valid) begin
               cur = {cmd_dev, cmd_rw, cmd_reg, cmd_wdata};
               cnt = ready_lat - 1;
               st = 1;
             end
          1: begin
               cnt--;
               if (cnt <= 0) begin cmd_ready = 1'b1; st = 3; end
             end
          3: begin
               cmd_ready = 1'b0;
               log_cmd(cur);
               cnt = rsp_lat - 1;
               st = 2;
             end
          2: begin
               cnt--;
               if (cnt <= 0) begin
                 reg_a = cur[15:8];
                 rsp_valid = 1'b1;
                 if (nack_left[reg_a] > 0) begin
                   nack_left[reg_a]--;
                   rsp_nack = 1'b1;
                   rsp_data = 8'h00;
                 end else begin
                   rsp_nack = 1'b0;
                   rsp_data = data_tbl[reg_a];
                   n_acks++;
                   if (cur[16] && reg_a >= 8'h3B && reg_a <= 8'h40) begin
                     ri = int'(reg_a) - 'h3B;
                     rec[ri] = data_tbl[reg_a];
                   end
                   if (cur[16] && reg_a == 8'h40) begin
                     last_rsp_cyc = cyc;
                     exp_smp_q.push_back({rec[0], rec[1], rec[2], rec[3], rec[4], rec[5]});
                   end
                 end
                 st = 4;
               end
             end
          default: begin
               rsp_valid = 1'b0;
               rsp_nack = 1'b0;
               st = 0;
             end
        endcase
      end
    end
  end

  // Command hold/drop monitor.
  initial begin : stab
    logic pv, pr;
    logic [23:0] pf;
    pv = 1'b0; pr = 1'b0; pf = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        if (pv && !pr)
          chk("cmd_hold", {23'h0, cmd_valid, cmd_dev, cmd_rw, cmd_reg, cmd_wdata}, {23'h0, 1'b1, pf});
        else if (pv && pr)
          chk("cmd_drop", cmd_valid, 0);
        pv = cmd_valid;
        pr = cmd_ready;
        pf = {cmd_dev, cmd_rw, cmd_reg, cmd_wdata};
      end
    end
  end

  // Sample scoreboard monitor.
  initial begin : smon
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && sample_valid) begin
        n_samples++;
        if (exp_smp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_unexpected actual=0x%0h required=none", {accel_x, accel_y, accel_z});
        end else begin
          chk("sample", {accel_x, accel_y, accel_z}, exp_smp_q.pop_front());
          chk("rsp_to_sample_cycles", 48'(cyc - last_rsp_cyc), 2);
        end
      end
    end
  end

  // Overrun counter monitor: +1 steps only, and drops spaced by whole tick periods.
  initial begin : omon
    logic [7:0] prev;
    int gap;
    prev = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev = 8'h00;
      end else begin
        if (overrun_cnt != prev) begin
          chk("ovr_step", {40'h0, 1'b0, overrun_cnt}, {40'h0, 9'({1'b0, prev} + 9'd1)});
          if (ov_phase) begin
            if (ov_last > 0) begin
              gap = cyc - ov_last;
              chk("ovr_gap_ok", (gap % 50 == 0) && (gap <= 100), 1);
            end
            ov_last = cyc;
          end
        end
        prev = overrun_cnt;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, a0, s0;
    bit seen;
    rst_n = 1'b0; enable = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 256; i++) begin data_tbl[i] = 8'h00; nack_left[i] = 0; end
    data_tbl[8'h3B] = 8'h12; data_tbl[8'h3C] = 8'h34; data_tbl[8'h3D] = 8'h80;
    data_tbl[8'h3E] = 8'h00; data_tbl[8'h3F] = 8'hFF; data_tbl[8'h40] = 8'hFE;
    repeat (3) step;

    // Reset values
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_rw", cmd_rw, 0);
    chk("rst_cmd_dev", cmd_dev, 7'h68);
    chk("rst_cmd_reg", cmd_reg, 0);
    chk("rst_cmd_wdata", cmd_wdata, 0);
    chk("rst_accel", {accel_x, accel_y, accel_z}, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_error", error, 0);
    chk("rst_overrun", overrun_cnt, 0);

    // Power-up delay and wake write
    exp_cmd_q.push_back({7'h68, 1'b0, 8'h6B, 8'h00});
    rst_n = 1'b1;
    n = 0;
    do begin step; n++; end while (!cmd_valid && n < 100);
    chk("pwrup_to_cmd_cycles", n, 9);
    n = 0;
    while (!init_done && n < 50) begin step; n++; end
    chk("init_done", init_done, 1);

    // Normal sample
    for (int i = 0; i < 6; i++) push_rd(8'h3B + 8'(i));
    s0 = n_samples;
    enable = 1'b1;
    wait_samples(s0 + 1, 200, "normal_sample_seen");
    enable = 1'b0;
    chk("accel_x_normal", accel_x, 16'h1234);
    chk("accel_y_normal", accel_y, 16'h8000);
    chk("accel_z_normal", accel_z, 16'hFFFE);
    chk("error_normal", error, 0);

    // NACK retry on 0x3D
    for (int i = 0; i < 6; i++) data_tbl[8'h3B + 8'(i)] = 8'(i + 1);
    nack_left[8'h3D] = 2;
    push_rd(8'h3B); push_rd(8'h3C); push_rd(8'h3D); push_rd(8'h3D);
    push_rd(8'h3D); push_rd(8'h3E); push_rd(8'h3F); push_rd(8'h40);
    s0 = n_samples;
    enable = 1'b1;
    wait_samples(s0 + 1, 300, "nack_sample_seen");
    enable = 1'b0;
    chk("accel_x_nack", accel_x, 16'h0102);
    chk("accel_y_nack", accel_y, 16'h0304);
    chk("accel_z_nack", accel_z, 16'h0506);
    chk("error_nack", error, 0);
    chk("cmd_q_empty_nack", exp_cmd_q.size(), 0);

    // Retry exhaustion on 0x3B
    for (int i = 0; i < 6; i++) data_tbl[8'h3B + 8'(i)] = 8'hAA;
    nack_left[8'h3B] = 4;
    repeat (4) push_rd(8'h3B);
    enable = 1'b1;
    n = 0;
    while (!error && n < 400) begin step; n++; end
    enable = 1'b0;
    chk("error_set", error, 1);
    seen = 1'b0;
    repeat (20) begin step; if (cmd_valid) seen = 1'b1; end
    chk("err_cmd_valid_low", seen, 0);
    chk("accel_x_kept", accel_x, 16'h0102);
    chk("accel_y_kept", accel_y, 16'h0304);
    chk("accel_z_kept", accel_z, 16'h0506);
    chk("cmd_q_empty_err", exp_cmd_q.size(), 0);
    chk("init_done_in_err", init_done, 1);

    exp_cmd_q.push_back({7'h68, 1'b0, 8'h6B, 8'h00});
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    chk("clr_error", error, 0);
    chk("clr_init_done", init_done, 0);
    n = 0;
    do begin step; n++; end while (!cmd_valid && n < 100);
    chk("clr_to_cmd_cycles", n, 9);
    n = 0;
    while (!init_done && n < 50) begin step; n++; end
    chk("reinit_done", init_done, 1);

    // Overrun with slow engine responses
    data_tbl[8'h3B] = 8'hDE; data_tbl[8'h3C] = 8'hAD; data_tbl[8'h3D] = 8'hBE;
    data_tbl[8'h3E] = 8'hEF; data_tbl[8'h3F] = 8'h00; data_tbl[8'h40] = 8'h01;
    rsp_lat = 40;
    cmd_chk = 1'b0;
    ov_last = 0;
    ov_phase = 1'b1;
    s0 = n_samples;
    enable = 1'b1;
    n = 0;
    while (overrun_cnt != 8'hFF && n < 40000) begin step; n++; end
    chk("ovr_reach_255", overrun_cnt, 8'hFF);
    repeat (400) step;
    chk("ovr_saturated", overrun_cnt, 8'hFF);
    chk("ovr_samples_continue", (n_samples - s0) >= 40, 1);
    enable = 1'b0;
    repeat (400) step;
    ov_phase = 1'b0;
    chk("accel_x_ovr", accel_x, 16'hDEAD);
    chk("accel_y_ovr", accel_y, 16'hBEEF);
    chk("accel_z_ovr", accel_z, 16'h0001);
    rsp_lat = 3;
    cmd_chk = 1'b1;

    // Reset after the third byte of a read
    push_rd(8'h3B); push_rd(8'h3C); push_rd(8'h3D);
    a0 = n_acks;
    enable = 1'b1;
    n = 0;
    while (n_acks < a0 + 3 && n < 300) begin step; n++; end
    chk("third_byte_seen", n_acks >= a0 + 3, 1);
    step;
    rst_n = 1'b0;
    enable = 1'b0;
    step;
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_cmd_reg", cmd_reg, 0);
    chk("mid_rst_accel", {accel_x, accel_y, accel_z}, 0);
    chk("mid_rst_sample_valid", sample_valid, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_overrun", overrun_cnt, 0);
    chk("cmd_q_empty_rst", exp_cmd_q.size(), 0);
    repeat (5) step;
    exp_cmd_q.push_back({7'h68, 1'b0, 8'h6B, 8'h00});
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 60) begin step; n++; end
    chk("init_after_rst", init_done, 1);
    repeat (60) step;
    chk("final_cmd_q_empty", exp_cmd_q.size(), 0);
    chk("final_smp_q_empty", exp_smp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
